// File: rtl/memory_bank_stack.sv
// rtl/memory_bank_stack.sv - active bank register with a hardware save/restore stack
module memory_bank_stack #(
    parameter int BANK_BITS   = 2,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_BANK  = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               write_en,
    input  logic [BANK_BITS-1:0]               in_data,
    input  logic                               push_en,
    input  logic                               pop_en,
    input  logic                               clr_err,
    output logic [BANK_BITS-1:0]               out_data,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [BANK_BITS-1:0] stack [STACK_DEPTH];
    logic [IW-1:0]        top_idx;
    logic [IW-1:0]        push_idx;

    // Indices are only used when the matching empty/full guard allows it,
    // so the truncation on the rejected cases is harmless.
    assign top_idx  = IW'(depth - PW'(1));
    assign push_idx = IW'(depth);

    assign full  = (depth == PW'(STACK_DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= BANK_BITS'(RESET_BANK);
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            // Later assignments win, so a same-cycle error overrides the clear.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (push_en && pop_en) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    out_data       <= stack[top_idx];
                    stack[top_idx] <= out_data;
                end
            end else if (pop_en) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    out_data <= stack[top_idx];
                    depth    <= depth - PW'(1);
                end
            end else if (push_en) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    stack[push_idx] <= out_data;
                    depth           <= depth + PW'(1);
                    if (write_en) begin
                        out_data <= in_data;
                    end
                end
            end else if (write_en) begin
                out_data <= in_data;
            end
        end
    end

endmodule
